alu_share_arbiter: RTL and testbench

//  Shares the single combinational 32-bit ALU (a, b, opcode -> c) between two requesters.
//  - Arbitrates round-robin and registers the winning operands.
//  - Drives the ALU for one cycle and captures its result.
//  - Returns the result on a valid/ready response channel tagged with the requester id.

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_share_arbiter_rr_arb2.sv | 30 +++
 rtl/alu_share_arbiter.sv | 108 ++++++++++
 tb/tb_alu_share_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU sharing block: widths, opcodes and FSM encoding.
package alu_pkg;

  localparam int ALU_W   = 32;
  localparam int ALU_OPW = 3;

  localparam logic [ALU_OPW-1:0] OP_SLA  = 3'b000;
  localparam logic [ALU_OPW-1:0] OP_SRAI = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way combinational round-robin arbiter; prio names the preferred requester.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] grant
);

  // Preferred requester wins when active, otherwise the other one.
  always_comb begin
    grant = 2'b00;
    if (prio == 1'b0) begin
      if (req[0]) begin
        grant = 2'b01;
      end else if (req[1]) begin
        grant = 2'b10;
      end else begin
        grant = 2'b00;
      end
    end else begin
      if (req[1]) begin
        grant = 2'b10;
      end else if (req[0]) begin
        grant = 2'b01;
      end else begin
        grant = 2'b00;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two requesters: arbitrate,
// drive the ALU for one cycle, then hold the tagged result until consumed.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int OPW   = ALU_OPW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  input  logic [2*OPW-1:0]   req_op,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [OPW-1:0]     alu_op,
  input  logic [WIDTH-1:0]   alu_c,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               rsp_id,
  output logic               busy
);

  state_t             state_r, state_n_s;
  logic               prio_r;
  logic               id_r;
  logic [WIDTH-1:0]   a_r, b_r, data_r;
  logic [OPW-1:0]     op_r;
  logic [1:0]         grant_s;
  logic               accept_s;

  rr_arb2 u_arb (
    .req   (req_valid),
    .prio  (prio_r),
    .grant (grant_s)
  );

  assign req_ready = (state_r == ST_IDLE) ? grant_s : 2'b00;
  assign accept_s  = |(req_valid & req_ready);

  // ALU inputs hold the last latched operands so they stay quiet outside EXEC.
  assign alu_a     = a_r;
  assign alu_b     = b_r;
  assign alu_op    = op_r;
  assign rsp_data  = data_r;
  assign rsp_id    = id_r;
  assign rsp_valid = (state_r == ST_RESP);
  assign busy      = (state_r != ST_IDLE);

  // Next-state logic for the IDLE -> EXEC -> RESP cycle.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_n_s = ST_EXEC;
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_EXEC: state_n_s = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          state_n_s = ST_IDLE;
        end else begin
          state_n_s = ST_RESP;
        end
      end
      default: state_n_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Operand latch on accept, result capture at the end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_r <= 1'b0;
      id_r   <= 1'b0;
      a_r    <= {WIDTH{1'b0}};
      b_r    <= {WIDTH{1'b0}};
      op_r   <= {OPW{1'b0}};
      data_r <= {WIDTH{1'b0}};
    end else begin
      if (accept_s) begin
        id_r   <= grant_s[1];
        prio_r <= ~grant_s[1];
        a_r    <= grant_s[1] ? req_a[WIDTH +: WIDTH] : req_a[0 +: WIDTH];
        b_r    <= grant_s[1] ? req_b[WIDTH +: WIDTH] : req_b[0 +: WIDTH];
        op_r   <= grant_s[1] ? req_op[OPW +: OPW]    : req_op[0 +: OPW];
      end
      if (state_r == ST_EXEC) begin
        data_r <= alu_c;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with an XOR stub ALU.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [63:0] req_a = 64'd0;
  logic [63:0] req_b = 64'd0;
  logic [5:0]  req_op = 6'd0;
  logic [31:0] alu_a, alu_b, alu_c;
  logic [2:0]  alu_op;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_id;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  alu_share_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  assign alu_c = alu_a ^ alu_b;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc_cyc [3];
    int acc_id  [3];
    int n_acc;

    // reset state
    #12;
    chk("rst_busy", busy, 32'd0);
    chk("rst_rsp_valid", rsp_valid, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_ready", req_ready, 32'd0);
    tick();
    rst_n = 1'b1;

    // 1. single request from req0
    req_a[31:0] = 32'hDDDDDDDD;
    req_b[31:0] = 32'h0000FFFF;
    req_op[2:0] = OP_SLA;
    req_valid   = 2'b01;
    #1;
    chk("t1_ready", req_ready, 32'd1);
    tick();
    req_valid = 2'b00;
    #1;
    chk("t1_exec_busy", busy, 32'd1);
    chk("t1_exec_op", alu_op, 32'd0);
    chk("t1_exec_a", alu_a, 32'hDDDDDDDD);
    chk("t1_exec_rv", rsp_valid, 32'd0);
    chk("t1_exec_ready", req_ready, 32'd0);
    tick();
    chk("t1_rsp_valid", rsp_valid, 32'd1);
    chk("t1_rsp_data", rsp_data, 32'hDDDD2222);
    chk("t1_rsp_id", rsp_id, 32'd0);
    rsp_ready = 1'b1;
    tick();
    chk("t1_idle_busy", busy, 32'd0);
    chk("t1_idle_rv", rsp_valid, 32'd0);

    // 6. stray ready in IDLE
    tick();
    tick();
    chk("t6_busy", busy, 32'd0);
    chk("t6_rv", rsp_valid, 32'd0);
    chk("t6_data", rsp_data, 32'hDDDD2222);
    rsp_ready = 1'b0;

    // 4. reset mid-EXEC (prio currently points at req1)
    req_a[63:32] = 32'h12345678;
    req_b[63:32] = 32'h0F0F0F0F;
    req_op[5:3]  = OP_SRAI;
    req_valid    = 2'b10;
    #1;
    chk("t4_ready", req_ready, 32'd2);
    tick();
    req_valid = 2'b00;
    chk("t4_exec_busy", busy, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_busy", busy, 32'd0);
    chk("t4_rst_rv", rsp_valid, 32'd0);
    chk("t4_rst_alu_a", alu_a, 32'd0);
    chk("t4_rst_data", rsp_data, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t4_after_rv", rsp_valid, 32'd0);
    chk("t4_after_busy", busy, 32'd0);

    // 2. contention from reset: alternation, accepts 3 cycles apart
    req_a     = {32'd10, 32'd1};
    req_b     = {32'd30, 32'd2};
    req_op    = {OP_SRAI, OP_SLA};
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    #1;
    n_acc = 0;
    for (int c = 0; c < 10; c++) begin
      if (req_ready != 2'b00) begin
        chk("t2_onehot", req_ready == 2'b01 || req_ready == 2'b10, 32'd1);
        if (n_acc < 3) begin
          acc_cyc[n_acc] = c;
          acc_id[n_acc]  = req_ready[1];
          n_acc++;
        end
      end
      if (rsp_valid) begin
        chk("t2_rsp_data", rsp_data, rsp_id ? 32'd20 : 32'd3);
      end
      tick();
    end
    req_valid = 2'b00;
    chk("t2_n_acc", n_acc, 32'd3);
    chk("t2_id0", acc_id[0], 32'd0);
    chk("t2_id1", acc_id[1], 32'd1);
    chk("t2_id2", acc_id[2], 32'd0);
    chk("t2_gap1", acc_cyc[1] - acc_cyc[0], 32'd3);
    chk("t2_gap2", acc_cyc[2] - acc_cyc[1], 32'd3);
    tick();
    tick();
    chk("t2_idle", busy, 32'd0);

    // 3. backpressure on a req1 op
    rsp_ready    = 1'b0;
    req_a[63:32] = 32'h40404040;
    req_b[63:32] = 32'h00000000;
    req_op[5:3]  = OP_SRAI;
    req_valid    = 2'b10;
    #1;
    chk("t3_ready", req_ready, 32'd2);
    tick();
    req_valid = 2'b00;
    chk("t3_exec_op", alu_op, 32'd1);
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("t3_hold_rv", rsp_valid, 32'd1);
      chk("t3_hold_data", rsp_data, 32'h40404040);
      chk("t3_hold_id", rsp_id, 32'd1);
      chk("t3_hold_ready", req_ready, 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("t3_idle", busy, 32'd0);
    chk("t3_idle_rv", rsp_valid, 32'd0);

    // 5. late valid from req1 during RESP of a req0 op
    rsp_ready    = 1'b0;
    req_a        = {32'd7, 32'd5};
    req_b        = {32'h100, 32'd3};
    req_op       = {OP_SRAI, OP_SLA};
    req_valid    = 2'b01;
    #1;
    chk("t5_ready0", req_ready, 32'd1);
    tick();
    req_valid = 2'b00;
    tick();
    chk("t5_rsp0", rsp_data, 32'd6);
    req_valid = 2'b10;
    #1;
    chk("t5_resp_ready_a", req_ready, 32'd0);
    tick();
    chk("t5_resp_ready_b", req_ready, 32'd0);
    rsp_ready = 1'b1;
    tick();
    chk("t5_idle_ready", req_ready, 32'd2);
    tick();
    req_valid = 2'b00;
    tick();
    chk("t5_rsp_valid", rsp_valid, 32'd1);
    chk("t5_rsp_id", rsp_id, 32'd1);
    chk("t5_rsp_data", rsp_data, 32'h107);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
